// File: rtl/ex_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_pkg
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
//   muldiv_op_e     : M-extension opcode, encoded exactly as funct3
//   muldiv_state_e  : iteration state machine states
//   forward_ctrl_e  : operand source select produced by the forwarding unit
//   MULDIV_ITER     : number of radix-2 iterations per operation
// ---------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

  localparam int MULDIV_XLEN = 32;
  localparam int MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

  typedef enum logic [1:0] {
    FORWARD_NONE     = 2'b00,
    FORWARD_FROM_WB  = 2'b01,
    FORWARD_FROM_MEM = 2'b10
  } forward_ctrl_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Operand A (rs1) is two's complement for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // Operand B (rs2) is two's complement for MULH, DIV and REM only.
  function automatic logic b_is_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_if
// Pipeline-side bundle of the EX-stage multiply/divide unit.
//   master : pipeline control (drives instruction, operands, forwarding, flush)
//   slave  : the muldiv unit (returns stall request and result)
// Signals:
//   valid_ex, funct3_ex, rs1_data_ex, rs2_data_ex : instruction in EX
//   fwd_data_mem, fwd_data_wb                       : forwarded results
//   forward_a, forward_b                            : operand source selects
//   flush_ex                                        : kill instruction in EX
//   stall_o, result_o, result_valid_o               : unit outputs
// ---------------------------------------------------------------------------
interface ex_muldiv_unit_if
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
);

  logic            valid_ex;
  muldiv_op_e      funct3_ex;
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [XLEN-1:0] fwd_data_mem;
  logic [XLEN-1:0] fwd_data_wb;
  forward_ctrl_e   forward_a;
  forward_ctrl_e   forward_b;
  logic            flush_ex;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  modport master (
    output valid_ex, funct3_ex, rs1_data_ex, rs2_data_ex,
           fwd_data_mem, fwd_data_wb, forward_a, forward_b, flush_ex,
    input  stall_o, result_o, result_valid_o
  );

  modport slave (
    input  valid_ex, funct3_ex, rs1_data_ex, rs2_data_ex,
           fwd_data_mem, fwd_data_wb, forward_a, forward_b, flush_ex,
    output stall_o, result_o, result_valid_o
  );

endinterface

// File: rtl/ex_operand_mux.sv
// ---------------------------------------------------------------------------
// ex_operand_mux
// 3:1 operand source select driven by the forwarding unit. Shared by the ALU
// and muldiv operand paths.
//   sel      : forward_ctrl_e source select
//   reg_data : register-file value
//   mem_data : result currently in MEM
//   wb_data  : writeback data currently in WB
//   data_o   : selected operand
// ---------------------------------------------------------------------------
module ex_operand_mux
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  forward_ctrl_e    sel,
  input  logic [WIDTH-1:0] reg_data,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves data_o
    // unassigned; otherwise synthesis infers a latch.
    data_o = reg_data;
    case (sel)
      FORWARD_FROM_MEM: data_o = mem_data;
      FORWARD_FROM_WB:  data_o = wb_data;
      default:          data_o = reg_data;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit in EX. Operands are picked from the
// register file or the forwarding paths in the start cycle, converted to
// magnitudes and latched; a radix-2 shift/add (multiply) or restoring
// shift/subtract (divide) loop then runs one bit per cycle, and the sign is
// fixed up on the final iteration. The pipeline is held with stall_o until
// the single-cycle DONE state presents the result.
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   bus    : ex_muldiv_unit_if.slave (instruction/operands in, stall/result out)
// ---------------------------------------------------------------------------
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN,
  parameter int ITER = MULDIV_ITER
) (
  input logic             clk,
  input logic             rst_n,
  ex_muldiv_unit_if.slave bus
);

  localparam int              CNT_W     = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // State and datapath registers
  muldiv_state_e     state_q;
  logic [CNT_W-1:0]  counter_q;
  muldiv_op_e        op_q;
  logic [2*XLEN-1:0] acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_q;     // multiplicand or divisor magnitude
  logic              negate_q;  // final result must be negated
  logic [XLEN-1:0]   result_q;
  logic              result_valid_q;

  // -------------------------------------------------------------------------
  // Operand selection (only meaningful in the start cycle)
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;

  ex_operand_mux #(.WIDTH(XLEN)) u_mux_a (
    .sel      (bus.forward_a),
    .reg_data (bus.rs1_data_ex),
    .mem_data (bus.fwd_data_mem),
    .wb_data  (bus.fwd_data_wb),
    .data_o   (src_a)
  );

  ex_operand_mux #(.WIDTH(XLEN)) u_mux_b (
    .sel      (bus.forward_b),
    .reg_data (bus.rs2_data_ex),
    .mem_data (bus.fwd_data_mem),
    .wb_data  (bus.fwd_data_wb),
    .data_o   (src_b)
  );

  // -------------------------------------------------------------------------
  // Start-cycle decode: magnitudes, result sign, special divide detection
  // -------------------------------------------------------------------------
  muldiv_op_e      op_in;
  logic            neg_a_in;
  logic            neg_b_in;
  logic            negate_in;
  logic            div_zero_in;
  logic            overflow_in;
  logic            special_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;
  logic [XLEN-1:0] special_res_in;

  assign op_in = bus.funct3_ex;

  always_comb begin
    neg_a_in    = a_is_signed(op_in) & src_a[XLEN-1];
    neg_b_in    = b_is_signed(op_in) & src_b[XLEN-1];
    mag_a_in    = neg_a_in ? (~src_a + 1'b1) : src_a;
    mag_b_in    = neg_b_in ? (~src_b + 1'b1) : src_b;
    // Remainder follows the dividend; product and quotient follow sign(a)^sign(b).
    negate_in   = is_rem(op_in) ? neg_a_in : (neg_a_in ^ neg_b_in);
    div_zero_in = is_div(op_in) && (src_b == '0);
    overflow_in = (op_in inside {OP_DIV, OP_REM}) && (src_a == INT_MIN) && (src_b == '1);
    special_in  = div_zero_in | overflow_in;

    special_res_in = '0;
    if (div_zero_in) begin
      special_res_in = is_rem(op_in) ? src_a : '1;
    end else if (overflow_in) begin
      special_res_in = is_rem(op_in) ? '0 : INT_MIN;
    end
  end

  // -------------------------------------------------------------------------
  // One radix-2 iteration and final sign fixup
  // -------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    // Shift/add: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right; the carry enters at the top.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring shift/subtract: shift the next dividend bit into the remainder
    // and keep the difference when it does not borrow.
    div_shift = acc_q[2*XLEN-2:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_diff[XLEN]) begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    acc_next = is_div(op_q) ? div_next : mul_next;

    prod_fix = negate_q ? (~acc_next + 1'b1) : acc_next;
    quot_fix = negate_q ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
    rem_fix  = negate_q ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];

    final_res = rem_fix;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quot_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  // -------------------------------------------------------------------------
  // State machine
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator and operand registers are plain flops, not a
      // memory, so clearing them on reset is cheap and keeps state deterministic.
      state_q        <= ST_IDLE;
      counter_q      <= '0;
      op_q           <= OP_MUL;
      acc_q          <= '0;
      opb_q          <= '0;
      negate_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.flush_ex) begin
        // Flush wins over everything, including a start in IDLE.
        state_q   <= ST_IDLE;
        counter_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.valid_ex) begin
              op_q      <= op_in;
              acc_q     <= {{XLEN{1'b0}}, mag_a_in};
              opb_q     <= mag_b_in;
              negate_q  <= negate_in;
              counter_q <= '0;
              if (special_in) begin
                result_q       <= special_res_in;
                result_valid_q <= 1'b1;
                state_q        <= ST_DONE;
              end else begin
                state_q <= ST_BUSY;
              end
            end
          end
          ST_BUSY: begin
            acc_q     <= acc_next;
            counter_q <= counter_q + 1'b1;
            if (counter_q == LAST_ITER) begin
              result_q       <= final_res;
              result_valid_q <= 1'b1;
              state_q        <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The stall is dropped during reset so the front end is never frozen by a
  // unit that has just lost its operation.
  assign bus.stall_o        = rst_n & bus.valid_ex & (state_q != ST_DONE) & ~bus.flush_ex;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = result_valid_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit. Expected results are pushed to a
// scoreboard queue when an operation starts and compared when result_valid_o
// is seen; each task also checks latency and stall profile inline.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the RV32M definition.
  function automatic logic [31:0] model(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [63:0]        p;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    r  = '0;
    case (op)
      OP_MUL:    begin p = ua * ub;           r = p[31:0];  end
      OP_MULH:   begin p = sa * sb;           r = p[63:32]; end
      OP_MULHSU: begin p = sa * $signed(ub);  r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub;           r = p[63:32]; end
      OP_DIV: begin
        if (b == 0)                               r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == '1)   r = 32'h8000_0000;
        else                                      r = $signed(a) / $signed(b);
      end
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0)                               r = a;
        else if (a == 32'h8000_0000 && b == '1)   r = 32'd0;
        else                                      r = $signed(a) % $signed(b);
      end
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Scoreboard: compare every produced result against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %h with nothing outstanding at %0t", bus.result_o, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.result_o !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h at %0t", bus.result_o, e, $time);
        end
      end
    end
  end

  task automatic drive_idle();
    bus.valid_ex     = 1'b0;
    bus.funct3_ex    = OP_MUL;
    bus.rs1_data_ex  = '0;
    bus.rs2_data_ex  = '0;
    bus.fwd_data_mem = '0;
    bus.fwd_data_wb  = '0;
    bus.forward_a    = FORWARD_NONE;
    bus.forward_b    = FORWARD_NONE;
    bus.flush_ex     = 1'b0;
  endtask

  // Run one operation from IDLE; call at posedge+1. Data inputs are scrambled
  // after the start cycle to prove the operands were latched.
  task automatic do_op(input muldiv_op_e op, input forward_ctrl_e fa, input forward_ctrl_e fb,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] mem, input logic [31:0] wb,
                       input logic [31:0] exp, input int exp_done, input string name);
    int done_k;
    int stall_cnt;
    bus.valid_ex     = 1'b1;
    bus.funct3_ex    = op;
    bus.forward_a    = fa;
    bus.forward_b    = fb;
    bus.rs1_data_ex  = rs1;
    bus.rs2_data_ex  = rs2;
    bus.fwd_data_mem = mem;
    bus.fwd_data_wb  = wb;
    bus.flush_ex     = 1'b0;
    exp_q.push_back(exp);
    done_k    = 0;
    stall_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (bus.stall_o === 1'b1) stall_cnt++;
      if (bus.result_valid_o === 1'b1) begin
        done_k = k;
        break;
      end
      @(posedge clk);
      #1;
      bus.rs1_data_ex  = $urandom;
      bus.rs2_data_ex  = $urandom;
      bus.fwd_data_mem = $urandom;
      bus.fwd_data_wb  = $urandom;
    end
    checks++;
    if (done_k !== exp_done) begin
      errors++;
      $display("FAIL %s latency: result_valid cycle %0d expected %0d", name, done_k, exp_done);
    end
    checks++;
    if (stall_cnt !== exp_done - 1) begin
      errors++;
      $display("FAIL %s stall: high for %0d cycles expected %0d", name, stall_cnt, exp_done - 1);
    end
    @(posedge clk);
    #1;
    bus.valid_ex = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.valid_ex = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.result_o !== 32'd0 || bus.result_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h valid=%b stall=%b expected 0/0/0",
               bus.result_o, bus.result_valid_o, bus.stall_o);
    end
    repeat (3) @(posedge clk);
    #1;
    bus.valid_ex = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_forward();
    do_op(OP_MUL, FORWARD_FROM_MEM, FORWARD_NONE, 32'd0, 32'hFFFF_FFFD, 32'd7, 32'd0,
          32'hFFFF_FFEB, 34, "mul_fwd_mem");
  endtask

  task automatic test_mul_high();
    do_op(OP_MULHU, FORWARD_NONE, FORWARD_FROM_WB, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 34, "mulhu");
    do_op(OP_MULH, FORWARD_FROM_WB, FORWARD_FROM_MEM, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0000_0000, 34, "mulh");
    do_op(OP_MULHSU, FORWARD_NONE, FORWARD_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
          32'hFFFF_FFFF, 34, "mulhsu");
  endtask

  task automatic test_div();
    do_op(OP_DIV,  FORWARD_NONE, FORWARD_NONE, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFD, 34, "div");
    do_op(OP_REM,  FORWARD_NONE, FORWARD_NONE, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 34, "rem");
    do_op(OP_DIVU, FORWARD_NONE, FORWARD_NONE, 32'd100, 32'd7, 32'd0, 32'd0, 32'd14, 34, "divu");
    do_op(OP_REMU, FORWARD_NONE, FORWARD_NONE, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 34, "remu");
  endtask

  task automatic test_special_div();
    do_op(OP_DIV,  FORWARD_NONE, FORWARD_NONE, 32'd5, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 2, "div_by_zero");
    do_op(OP_REMU, FORWARD_NONE, FORWARD_NONE, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 2, "remu_by_zero");
    do_op(OP_DIV,  FORWARD_NONE, FORWARD_NONE, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
          32'h8000_0000, 2, "div_overflow");
    do_op(OP_REM,  FORWARD_NONE, FORWARD_NONE, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
          32'd0, 2, "rem_overflow");
  endtask

  task automatic test_flush();
    int seen;
    // Start a multiply that will be killed; nothing is pushed for it.
    bus.valid_ex    = 1'b1;
    bus.funct3_ex   = OP_MUL;
    bus.rs1_data_ex = 32'd5;
    bus.rs2_data_ex = 32'd6;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flush_ex = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b expected 0", bus.stall_o);
    end
    @(posedge clk);
    #1;
    bus.flush_ex = 1'b0;
    bus.valid_ex = 1'b0;
    #1;
    checks++;
    if (bus.result_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: valid=%b stall=%b expected 0/0", bus.result_valid_o, bus.stall_o);
    end
    // Immediately following ops prove the unit restarted from IDLE.
    do_op(OP_MUL,  FORWARD_NONE, FORWARD_NONE, 32'd3, 32'd4, 32'd0, 32'd0, 32'd12, 34, "mul_after_flush");
    do_op(OP_DIVU, FORWARD_FROM_MEM, FORWARD_FROM_WB, 32'd0, 32'd0, 32'd81, 32'd9, 32'd9, 34, "back_to_back");
    // Flush must beat a start in IDLE.
    bus.valid_ex  = 1'b1;
    bus.funct3_ex = OP_MULHU;
    bus.flush_ex  = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority_stall: stall=%b expected 0", bus.stall_o);
    end
    @(posedge clk);
    #1;
    bus.valid_ex = 1'b0;
    bus.flush_ex = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.result_valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_result: result_valid seen %0d times expected 0", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      muldiv_op_e    op;
      forward_ctrl_e fa;
      forward_ctrl_e fb;
      logic [31:0]   rs1, rs2, mem, wb, ea, eb;
      int            done;
      op  = muldiv_op_e'(3'($urandom_range(0, 7)));
      fa  = forward_ctrl_e'(2'($urandom_range(0, 2)));
      fb  = forward_ctrl_e'(2'($urandom_range(0, 2)));
      rs1 = $urandom;
      rs2 = (i == 4) ? 32'd0 : $urandom;
      mem = $urandom;
      wb  = $urandom;
      if (i == 4) fb = FORWARD_NONE;
      ea  = (fa == FORWARD_FROM_MEM) ? mem : (fa == FORWARD_FROM_WB) ? wb : rs1;
      eb  = (fb == FORWARD_FROM_MEM) ? mem : (fb == FORWARD_FROM_WB) ? wb : rs2;
      done = 34;
      if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && eb == 0) done = 2;
      if (op inside {OP_DIV, OP_REM} && ea == 32'h8000_0000 && eb == '1) done = 2;
      do_op(op, fa, fb, rs1, rs2, mem, wb, model(op, ea, eb), done, "random");
    end
  endtask

  task automatic test_reset_mid_busy();
    do_op(OP_MUL, FORWARD_NONE, FORWARD_NONE, 32'd2, 32'd5, 32'd0, 32'd0, 32'd10, 34, "mul_before_reset");
    bus.valid_ex    = 1'b1;
    bus.funct3_ex   = OP_DIVU;
    bus.rs1_data_ex = 32'd1000;
    bus.rs2_data_ex = 32'd3;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_o !== 32'd0 || bus.result_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: result=%h valid=%b stall=%b expected 0/0/0",
               bus.result_o, bus.result_valid_o, bus.stall_o);
    end
    bus.valid_ex = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(OP_MUL, FORWARD_NONE, FORWARD_NONE, 32'd2, 32'd3, 32'd0, 32'd0, 32'd6, 34, "mul_after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul_forward();
    test_mul_high();
    test_div();
    test_special_div();
    test_flush();
    test_random();
    test_reset_mid_busy();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the forwarding unit.
- Selects each operand from register-file data, the MEM-stage result or the WB-stage result, using forward_a/forward_b (forwardCtrl_e).
- Latches both operands at start, runs a radix-2 shift/add or shift/subtract loop, and holds the pipeline with a stall request until the result is ready.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
ITER, 32, iteration count; must equal XLEN.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
valid_ex  in  1  M-extension instruction is present in EX
funct3_ex  in  3  muldivOp_e opcode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
rs1_data_ex  in  XLEN  register-file value of rs1
rs2_data_ex  in  XLEN  register-file value of rs2
fwd_data_mem  in  XLEN  result in MEM stage
fwd_data_wb  in  XLEN  writeback data in WB stage
forward_a  in  forwardCtrl_e  operand-A source select
forward_b  in  forwardCtrl_e  operand-B source select
flush_ex  in  1  kill the instruction in EX
stall_o  out  1  freeze PC/IF/ID/EX; insert a bubble into MEM
result_o  out  XLEN  final result
result_valid_o  out  1  result_o is valid this cycle

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE, counter=0, result_o=0, result_valid_o=0, stall_o=0.
- All operand and accumulator registers are cleared.

Operand selection (combinational, used only in the start cycle):
- FORWARD_FROM_MEM selects fwd_data_mem.
- FORWARD_FROM_WB selects fwd_data_wb.
- FORWARD_NONE selects rs*_data_ex.

Latching:
- Operands and funct3 are latched on the start edge.
- Later changes on the forwarding or data inputs must not affect the result. While stalled, MEM/WB drain, so the forwarded values go stale.

State machine (muldivState_e):
- IDLE: if valid_ex & ~flush_ex, latch operands and go to BUSY with counter=0. Special divides go straight to DONE instead.
- BUSY: one iteration per cycle; counter increments. When counter reaches ITER-1, apply sign fixup and go to DONE.
- DONE: result_valid_o=1 for exactly one cycle, result_o holds the value. Return to IDLE. The instruction leaves EX on this edge.

Stall:
- stall_o = valid_ex & (state != DONE) & ~flush_ex (combinational).
- Normal op: EX occupancy is 34 cycles (1 start, 32 BUSY, 1 DONE); stall_o is high for 33 of them.
- Special case: EX occupancy is 2 cycles; stall_o is high for 1.

Arithmetic:
- Signed operands are converted to magnitudes, computed unsigned, then negated if required.
- Multiply: MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32] with ss, su and uu signedness respectively.
- Divide: quotient is negative when operand signs differ (signed ops only). Remainder takes the sign of the dividend.
- Divide by zero: quotient=0xFFFFFFFF; remainder=dividend.
- Signed overflow (0x80000000 / -1): quotient=0x80000000; remainder=0.

Flush:
- flush_ex in any state forces IDLE on the next edge and clears counter.
- No result_valid_o is produced for the killed operation.
- Flush has priority over start.

Back-to-back:
- A muldiv instruction arriving in EX in the cycle after DONE starts normally from IDLE.

Decomposition:
- types.svh holds:
  - muldivOp_e, encoded as funct3: 000 MUL … 111 REMU.
  - muldivState_e: IDLE, BUSY, DONE.
  - MULDIV_ITER constant.
- Reuses the existing forwardCtrl_e.
- Sub-module ex_operand_mux (3:1 select on forwardCtrl_e), shared with the ALU operand path.

Test Plan:
1. MUL, forward_a=FROM_MEM, fwd_data_mem=7, rs1_data_ex=0, rs2_data_ex=0xFFFFFFFD -> result 0xFFFFFFEB, result_valid_o in cycle 34, stall_o high cycles 1-33.
2. Both operands 0xFFFFFFFF:
   - MULHU -> 0xFFFFFFFE.
   - MULH -> 0x00000000.
   - MULHSU -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Special divides, each result_valid_o on cycle 2:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Flush, late input change and back-to-back:
   - flush_ex pulsed in BUSY cycle 10 -> IDLE next cycle, stall_o=0, no result_valid_o.
   - fwd_data_mem changed during BUSY -> result unchanged.
   - Immediate following MUL 3*4 -> 12.
6. rst_n asserted mid-BUSY -> result_o=0, result_valid_o=0, stall_o=0 immediately (asynchronous). After release, MUL 2*3 -> 6.
